sra_shifter: RTL and testbench

- Registered 32-bit arithmetic shift-right (MIPS SRA) unit for the ALU/shift datapath.
- Shifts operand rt right by a 5-bit unsigned amount shamt and replicates the sign bit rt[31] into the vacated MSBs.
- Built as a five-stage logarithmic (barrel) mux network, with a one-cycle output register and a simple valid flag.

---
 rtl/alu_pkg.sv | 10 +
 rtl/sra_stage.sv | 21 ++
 rtl/sra_shifter.sv | 65 ++++++
 tb/tb_sra_shifter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU datapath constants and types.
package alu_pkg;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [SHW-1:0]   shamt_t;

endpackage : alu_pkg

// File: rtl/sra_stage.sv
// One stage of the arithmetic-right barrel shifter: shifts by a fixed SHIFT
// with sign fill when enabled, otherwise passes data straight through.
module sra_stage #(
    parameter int WIDTH = 32,
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             en,
    input  logic             sign,
    output logic [WIDTH-1:0] data_out
);

    // Select between the shifted (sign-filled) word and the unshifted word.
    always_comb begin
        data_out = data_in;
        if (en) begin
            data_out = {{SHIFT{sign}}, data_in[WIDTH-1:SHIFT]};
        end
    end

endmodule : sra_stage

// File: rtl/sra_shifter.sv
// Registered 32-bit arithmetic shift right (MIPS SRA). A log2(WIDTH)-stage
// mux network computes rt >>> shamt; the result and a valid flag are
// registered, giving a fixed one-cycle latency at full throughput.
module sra_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int SHW   = alu_pkg::SHW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] rt,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] rd,
    output logic             out_valid
);

    // stage_data[k] feeds stage k; stage_data[SHW] is the final result.
    logic [WIDTH-1:0] stage_data [0:SHW];
    logic             sign_bit;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] rd_reg;
    logic             out_valid_reg;

    // The operand's sign bit fills vacated MSBs in every stage, so the fill
    // never depends on intermediate results.
    assign sign_bit      = rt[WIDTH-1];
    assign stage_data[0] = rt;

    // Stage k shifts by 2^k when shamt[k] is set; stages run in order 0..SHW-1.
    generate
        for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
            sra_stage #(
                .WIDTH (WIDTH),
                .SHIFT (1 << gi)
            ) u_stage (
                .data_in  (stage_data[gi]),
                .en       (shamt[gi]),
                .sign     (sign_bit),
                .data_out (stage_data[gi+1])
            );
        end
    endgenerate

    assign res_next = stage_data[SHW];

    // Output register: reset clears both; accepted ops load rd, idle cycles
    // hold rd but drop the valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_reg        <= '0;
            out_valid_reg <= 1'b0;
        end else if (in_valid) begin
            rd_reg        <= res_next;
            out_valid_reg <= 1'b1;
        end else begin
            out_valid_reg <= 1'b0;
        end
    end

    assign rd        = rd_reg;
    assign out_valid = out_valid_reg;

endmodule : sra_shifter

// File: tb/tb_sra_shifter.sv
// Directed and random checks of the registered arithmetic shifter.
module tb_sra_shifter;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] rt;
    logic [4:0]  shamt;
    logic [31:0] rd;
    logic        out_valid;

    int total  = 0;
    int passed = 0;

    sra_shifter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .rt        (rt),
        .shamt     (shamt),
        .rd        (rd),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_sra(input logic [31:0] a, input logic [4:0] s);
        logic signed [31:0] sa;
        sa = a;
        return sa >>> s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs, then land 1 time unit after the capturing edge.
    task automatic step(input logic r, input logic v, input logic [31:0] a, input logic [4:0] s);
        rst      = r;
        in_valid = v;
        rt       = a;
        shamt    = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [4:0]  s;
        logic [31:0] pat;

        rst = 1'b1; in_valid = 1'b1; rt = 32'hFFFF_FFFF; shamt = 5'd0;

        // Reset held 2 cycles with a valid op presented.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 32'hFFFF_FFFF, 5'd0);
            chk($sformatf("reset_rd_%0d", i), rd, 32'h0);
            chk($sformatf("reset_vld_%0d", i), {31'b0, out_valid}, 32'h0);
        end
        step(1'b0, 1'b0, 32'hFFFF_FFFF, 5'd0);
        chk("post_reset_vld", {31'b0, out_valid}, 32'h0);
        chk("post_reset_rd", rd, 32'h0);

        // Negative operands.
        step(1'b0, 1'b1, 32'h8000_FFFF, 5'd1);
        chk("neg_sh1", rd, 32'hC000_7FFF);
        chk("neg_sh1_vld", {31'b0, out_valid}, 32'h1);
        step(1'b0, 1'b1, 32'h87FF_FFE0, 5'd3);
        chk("neg_sh3", rd, 32'hF0FF_FFFC);

        // Full shifts.
        step(1'b0, 1'b1, 32'h07C1_FFE0, 5'd31);
        chk("pos_sh31", rd, 32'h0000_0000);
        step(1'b0, 1'b1, 32'h8000_0000, 5'd31);
        chk("neg_sh31", rd, 32'hFFFF_FFFF);

        // Pass-through then hold.
        step(1'b0, 1'b1, 32'h1234_5678, 5'd0);
        chk("sh0", rd, 32'h1234_5678);
        chk("sh0_vld", {31'b0, out_valid}, 32'h1);
        step(1'b0, 1'b0, 32'hDEAD_BEEF, 5'd7);
        chk("hold_rd", rd, 32'h1234_5678);
        chk("hold_vld", {31'b0, out_valid}, 32'h0);

        // Back-to-back sweep of all shift amounts.
        pat = 32'hA5A5_A5A5;
        for (int i = 0; i < 32; i++) begin
            s = i[4:0];
            step(1'b0, 1'b1, pat, s);
            chk($sformatf("sweep_%0d", i), rd, ref_sra(pat, s));
            chk($sformatf("sweep_vld_%0d", i), {31'b0, out_valid}, 32'h1);
        end

        // Random back-to-back operations.
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            s = 5'($urandom_range(0, 31));
            step(1'b0, 1'b1, a, s);
            chk($sformatf("rand_%0d", i), rd, ref_sra(a, s));
        end

        // Reset during a burst.
        step(1'b0, 1'b1, 32'hF000_0000, 5'd4);
        chk("burst_a", rd, 32'hFF00_0000);
        step(1'b1, 1'b1, 32'h8000_0001, 5'd2);
        chk("midrst_rd", rd, 32'h0);
        chk("midrst_vld", {31'b0, out_valid}, 32'h0);
        step(1'b0, 1'b0, 32'h8000_0001, 5'd2);
        chk("release_rd", rd, 32'h0);
        chk("release_vld", {31'b0, out_valid}, 32'h0);
        step(1'b0, 1'b1, 32'h4000_0000, 5'd30);
        chk("resume_rd", rd, 32'h0000_0001);
        chk("resume_vld", {31'b0, out_valid}, 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_sra_shifter
